// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, field positions and decoded bundle type for the decode stage
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 5;
    localparam int ALU_W   = 3;

    function automatic int imm_w(input int instr_width, input int opc_width, input int reg_width);
        return instr_width - opc_width - 2 * reg_width;
    endfunction

    localparam int IMM_W     = imm_w(INSTR_W, OPC_W, REG_W);
    localparam int OPC_LSB   = INSTR_W - OPC_W;
    localparam int DEST_LSB  = OPC_LSB - REG_W;
    localparam int SRC_A_LSB = DEST_LSB - REG_W;
    localparam int SRC_B_LSB = SRC_A_LSB - REG_W;

    localparam logic [OPC_W-1:0] OP_NOP        = 4'h0;
    localparam logic [OPC_W-1:0] OP_ALU_RR_LO  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ALU_RR_HI  = 4'h7;
    localparam logic [OPC_W-1:0] OP_ALU_IMM_LO = 4'h8;
    localparam logic [OPC_W-1:0] OP_ALU_IMM_HI = 4'hB;
    localparam logic [OPC_W-1:0] OP_LOAD       = 4'hC;
    localparam logic [OPC_W-1:0] OP_STORE      = 4'hD;
    localparam logic [OPC_W-1:0] OP_BRANCH     = 4'hE;
    localparam logic [OPC_W-1:0] OP_HALT       = 4'hF;

    typedef struct packed {
        logic             read_src_a;
        logic             read_src_b;
        logic [REG_W-1:0] src_a;
        logic [REG_W-1:0] src_b;
        logic             write_dest;
        logic [REG_W-1:0] dest;
        logic             alu_en;
        logic [ALU_W-1:0] alu_op;
        logic             use_imm;
        logic [IMM_W-1:0] imm;
        logic             mem_rd;
        logic             mem_wr;
        logic             branch;
        logic             halt;
    } decoded_t;

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational instruction word to decoded bundle
module instr_field_decode
    import decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output decoded_t           dec
);

    logic [OPC_W-1:0] opc;

    assign opc = instr[OPC_LSB +: OPC_W];

    always_comb begin
        dec        = '0;
        dec.dest   = instr[DEST_LSB +: REG_W];
        dec.src_a  = instr[SRC_A_LSB +: REG_W];
        dec.src_b  = instr[SRC_B_LSB +: REG_W];
        dec.imm    = instr[IMM_W-1:0];
        case (opc)
            OP_NOP: begin
            end
            OP_LOAD: begin
                dec.read_src_a = 1'b1;
                dec.write_dest = 1'b1;
                dec.mem_rd     = 1'b1;
                dec.use_imm    = 1'b1;
            end
            OP_STORE: begin
                dec.read_src_a = 1'b1;
                dec.read_src_b = 1'b1;
                dec.mem_wr     = 1'b1;
                dec.use_imm    = 1'b1;
            end
            OP_BRANCH: begin
                dec.read_src_a = 1'b1;
                dec.read_src_b = 1'b1;
                dec.branch     = 1'b1;
            end
            OP_HALT: begin
                dec.halt = 1'b1;
            end
            default: begin
                // remaining opcodes are the two ALU groups
                dec.read_src_a = 1'b1;
                dec.write_dest = 1'b1;
                dec.alu_en     = 1'b1;
                if (opc <= OP_ALU_RR_HI) begin
                    dec.read_src_b = 1'b1;
                    dec.alu_op     = opc[ALU_W-1:0];
                end else begin
                    dec.use_imm = 1'b1;
                    dec.alu_op  = {1'b0, opc[1:0]};
                end
            end
        endcase
        // r0 is hardwired zero, so a write to it is discarded here
        if (dec.dest == '0) begin
            dec.write_dest = 1'b0;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered decode stage with hazard scoreboard and HALT state machine
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_WIDTH     = 32,
    parameter int OPCODE_WIDTH    = 4,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int ALU_OP_WIDTH    = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   in_valid,
    output logic                                                   in_ready,
    input  logic [INSTR_WIDTH-1:0]                                 instr_in,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic                                                   read_src_a,
    output logic                                                   read_src_b,
    output logic [REG_ADDR_WIDTH-1:0]                              src_reg_addr_a,
    output logic [REG_ADDR_WIDTH-1:0]                              src_reg_addr_b,
    output logic                                                   write_dest,
    output logic [REG_ADDR_WIDTH-1:0]                              dest_reg_addr,
    output logic                                                   alu_en,
    output logic [ALU_OP_WIDTH-1:0]                                alu_op,
    output logic                                                   use_imm,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH-1:0]   imm,
    output logic                                                   mem_rd,
    output logic                                                   mem_wr,
    output logic                                                   branch,
    output logic                                                   halt,
    input  logic                                                   wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]                              wb_addr,
    input  logic                                                   flush,
    input  logic                                                   resume,
    output logic                                                   halted,
    output logic [STALL_CNT_WIDTH-1:0]                             stall_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;
    localparam int         NUM_REGS  = 1 << REG_ADDR_WIDTH;

    // the shared decoded_t layout fixes the field widths
    if (OPCODE_WIDTH != 4) begin : g_bad_opcode_width
        $error("decode_stage: OPCODE_WIDTH must be 4");
    end
    if (INSTR_WIDTH != INSTR_W || REG_ADDR_WIDTH != REG_W || ALU_OP_WIDTH != ALU_W) begin : g_bad_widths
        $error("decode_stage: widths must match decode_pkg");
    end

    decoded_t            dec;
    decoded_t            out_q;
    logic [0:0]          state;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;
    logic                hazard;
    logic                accept;

    instr_field_decode u_field_decode (
        .instr (instr_in),
        .dec   (dec)
    );

    // a retiring register still stalls this cycle: there is no bypass
    assign hazard = (dec.read_src_a && (dec.src_a != '0) && sb[dec.src_a])
                 || (dec.read_src_b && (dec.src_b != '0) && sb[dec.src_b])
                 || (dec.write_dest && sb[dec.dest]);

    assign in_ready = !rst && (state == ST_RUN) && !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        sb_next = sb;
        if (wb_valid) begin
            sb_next[wb_addr] = 1'b0;
        end
        if (flush && out_valid && out_q.write_dest) begin
            sb_next[out_q.dest] = 1'b0;
        end
        if (accept && dec.write_dest) begin
            sb_next[dec.dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            out_valid <= 1'b0;
            out_q     <= '0;
            sb        <= '0;
            stall_cnt <= '0;
        end else begin
            sb <= sb_next;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                out_q <= dec;
            end
            if (in_valid && hazard && (state == ST_RUN) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            case (state)
                ST_RUN:    if (accept && dec.halt) state <= ST_HALTED;
                ST_HALTED: if (resume) state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

    assign halted         = (state == ST_HALTED);
    assign read_src_a     = out_q.read_src_a;
    assign read_src_b     = out_q.read_src_b;
    assign src_reg_addr_a = out_q.src_a;
    assign src_reg_addr_b = out_q.src_b;
    assign write_dest     = out_q.write_dest;
    assign dest_reg_addr  = out_q.dest;
    assign alu_en         = out_q.alu_en;
    assign alu_op         = out_q.alu_op;
    assign use_imm        = out_q.use_imm;
    assign imm            = out_q.imm;
    assign mem_rd         = out_q.mem_rd;
    assign mem_wr         = out_q.mem_wr;
    assign branch         = out_q.branch;
    assign halt           = out_q.halt;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        read_src_a, read_src_b, write_dest, alu_en, use_imm;
    logic [4:0]  src_reg_addr_a, src_reg_addr_b, dest_reg_addr;
    logic [2:0]  alu_op;
    logic [17:0] imm;
    logic        mem_rd, mem_wr, branch, halt;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic        flush = 1'b0;
    logic        resume = 1'b0;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [8:0]  dut_flags;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .read_src_a(read_src_a), .read_src_b(read_src_b),
        .src_reg_addr_a(src_reg_addr_a), .src_reg_addr_b(src_reg_addr_b),
        .write_dest(write_dest), .dest_reg_addr(dest_reg_addr),
        .alu_en(alu_en), .alu_op(alu_op), .use_imm(use_imm), .imm(imm),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .branch(branch), .halt(halt),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .resume(resume),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    assign dut_flags = {read_src_a, read_src_b, write_dest, alu_en, use_imm, mem_rd, mem_wr, branch, halt};

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  d, a, b;
        logic [12:0] low;
        logic [8:0]  flags;
        logic [2:0]  aop;
    } vec_t;

    typedef struct {
        bit ra, rb, wd, alu, ui, mrd, mwr, br, hlt;
        bit [2:0]  aop;
        bit [4:0]  d, a, b;
        bit [17:0] imm;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; resume = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; instr = '0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   op;
        op    = int'(w[31:28]);
        e.d   = w[27:23];
        e.a   = w[22:18];
        e.b   = w[17:13];
        e.imm = w[17:0];
        e.ra  = (op >= 1 && op <= 14);
        e.rb  = (op >= 1 && op <= 7) || op == 13 || op == 14;
        e.wd  = (op >= 1 && op <= 12) && (e.d != 0);
        e.alu = (op >= 1 && op <= 11);
        e.ui  = (op >= 8 && op <= 13);
        e.mrd = (op == 12);
        e.mwr = (op == 13);
        e.br  = (op == 14);
        e.hlt = (op == 15);
        e.aop = (op >= 1 && op <= 7) ? 3'(op) : (op >= 8 && op <= 11) ? 3'(op - 8) : 3'd0;
        return e;
    endfunction

    function automatic logic [8:0] flags_of(input exp_t e);
        return {e.ra, e.rb, e.wd, e.alu, e.ui, e.mrd, e.mwr, e.br, e.hlt};
    endfunction

    vec_t vecs[11];

    // random-run model state
    bit   pend[32];
    bit   m_ov, m_halted, hz, rdy, acc;
    exp_t m_held, d;
    int   m_cnt;

    initial begin
        vecs[0]  = '{4'h1, 5'd3, 5'd1, 5'd2, 13'h0000, 9'b111100000, 3'd1};
        vecs[1]  = '{4'h7, 5'd5, 5'd6, 5'd7, 13'h1abc, 9'b111100000, 3'd7};
        vecs[2]  = '{4'h1, 5'd0, 5'd1, 5'd2, 13'h0000, 9'b110100000, 3'd1};
        vecs[3]  = '{4'h0, 5'd4, 5'd4, 5'd4, 13'h0123, 9'b000000000, 3'd0};
        vecs[4]  = '{4'hB, 5'd9, 5'd2, 5'd3, 13'h1fff, 9'b101110000, 3'd3};
        vecs[5]  = '{4'h8, 5'd9, 5'd2, 5'd3, 13'h0001, 9'b101110000, 3'd0};
        vecs[6]  = '{4'hC, 5'd6, 5'd7, 5'd8, 13'h0040, 9'b101011000, 3'd0};
        vecs[7]  = '{4'hD, 5'd6, 5'd7, 5'd8, 13'h0040, 9'b110010100, 3'd0};
        vecs[8]  = '{4'hE, 5'd1, 5'd2, 5'd3, 13'h0800, 9'b110000010, 3'd0};
        vecs[9]  = '{4'hF, 5'd1, 5'd2, 5'd3, 13'h0000, 9'b000000001, 3'd0};
        vecs[10] = '{4'hC, 5'd0, 5'd1, 5'd1, 13'h0002, 9'b100011000, 3'd0};

        // reset state, with an instruction already offered
        rst = 1'b1; in_valid = 1'b1; instr = 32'h11844000; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flags", dut_flags, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("first_out_valid", out_valid, 1);
        chk("first_dest", dest_reg_addr, 3);
        chk("first_srcs", {src_reg_addr_a, src_reg_addr_b}, {5'd1, 5'd2});
        chk("first_alu_op", alu_op, 1);
        chk("first_write_dest", write_dest, 1);

        // RAW on r3, released only the cycle after writeback
        instr = 32'h120C0000;
        @(negedge clk);
        chk("raw_in_ready", in_ready, 0);
        chk("raw_stall_cnt0", stall_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("raw_stall_cnt3", stall_cnt, 3);
        chk("raw_out_drained", out_valid, 0);
        wb_valid = 1'b1; wb_addr = 5'd3;
        @(negedge clk);
        chk("raw_no_bypass", in_ready, 0);
        @(posedge clk); #1;
        wb_valid = 1'b0;
        chk("raw_stall_cnt4", stall_cnt, 4);
        @(negedge clk);
        chk("raw_released", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("raw_out_valid", out_valid, 1);
        chk("raw_dest_src", {dest_reg_addr, src_reg_addr_a}, {5'd4, 5'd3});
        chk("raw_stall_hold", stall_cnt, 4);

        // table-driven decode checks
        for (int i = 0; i < 11; i++) begin
            do_reset();
            instr = {vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].low};
            in_valid = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_out_valid", out_valid, 1);
            chk("vec_flags", dut_flags, vecs[i].flags);
            chk("vec_alu_op", alu_op, vecs[i].aop);
            chk("vec_regs", {dest_reg_addr, src_reg_addr_a, src_reg_addr_b}, {vecs[i].d, vecs[i].a, vecs[i].b});
            chk("vec_imm", imm, {vecs[i].b, vecs[i].low});
        end

        // write to r0 then read r0: no scoreboard effect
        do_reset();
        instr = 32'h10044000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("r0_out_valid", out_valid, 1);
        chk("r0_write_dest", write_dest, 0);
        instr = 32'h12800000;
        @(negedge clk);
        chk("r0_no_stall", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("r0_b2b_dest", dest_reg_addr, 5);
        chk("r0_stall_cnt", stall_cnt, 0);

        // backpressure holds the bundle stable
        do_reset();
        out_ready = 1'b0; instr = 32'h11844000; in_valid = 1'b1;
        @(posedge clk); #1;
        instr = {4'h1, 5'd6, 5'd7, 5'd8, 13'h0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_stable", {dut_flags, dest_reg_addr, src_reg_addr_a, src_reg_addr_b, imm},
                {9'b111100000, 5'd3, 5'd1, 5'd2, 18'h04000});
            @(posedge clk);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_dest", {out_valid, dest_reg_addr}, {1'b1, 5'd6});

        // HALT, hold, resume
        do_reset();
        instr = 32'hF0000000; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("halt_bundle", {out_valid, halt, dut_flags}, {1'b1, 1'b1, 9'b000000001});
        chk("halt_halted", halted, 1);
        instr = {4'h1, 5'd6, 5'd7, 5'd8, 13'h0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("halt_in_ready", in_ready, 0);
            @(posedge clk);
        end
        #1;
        chk("halt_drained", out_valid, 0);
        chk("halt_still_halted", halted, 1);
        resume = 1'b1;
        @(negedge clk);
        chk("resume_cycle_ready", in_ready, 0);
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resume_halted", halted, 0);
        @(negedge clk);
        chk("resume_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("resume_fetch", {out_valid, dest_reg_addr}, {1'b1, 5'd6});
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        chk("resume_in_run", halted, 0);

        // flush drops the held bundle and its scoreboard bit
        do_reset();
        out_ready = 1'b0; instr = 32'h11844000; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b1; out_ready = 1'b1; instr = {4'h1, 5'd6, 5'd7, 5'd8, 13'h0};
        @(negedge clk);
        chk("flush_cycle_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_halted", halted, 0);
        instr = 32'h120C0000;
        @(negedge clk);
        chk("flush_sb_clear", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("flush_next", {out_valid, dest_reg_addr}, {1'b1, 5'd4});
        chk("flush_stall_cnt", stall_cnt, 0);

        // randomized traffic against the reference model
        do_reset();
        for (int r = 0; r < 32; r++) pend[r] = 1'b0;
        m_ov = 1'b0; m_halted = 1'b0; m_cnt = 0; m_held = ref_decode(32'h0);
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            instr     = {4'($urandom_range(15)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                         5'($urandom_range(7)), 13'($urandom)};
            out_ready = ($urandom_range(9) < 7);
            flush     = ($urandom_range(19) == 0);
            resume    = ($urandom_range(4) == 0);
            wb_valid  = ($urandom_range(9) < 4);
            wb_addr   = 5'($urandom_range(7));
            @(negedge clk);
            d   = ref_decode(instr);
            hz  = (d.ra && d.a != 0 && pend[d.a]) || (d.rb && d.b != 0 && pend[d.b]) || (d.wd && pend[d.d]);
            rdy = !m_halted && !hz && (!m_ov || out_ready) && !flush;
            acc = in_valid && rdy;
            chk("rnd_in_ready", in_ready, rdy);
            chk("rnd_out_valid", out_valid, m_ov);
            if (m_ov) begin
                chk("rnd_flags", dut_flags, flags_of(m_held));
                chk("rnd_fields", {alu_op, dest_reg_addr, src_reg_addr_a, src_reg_addr_b, imm},
                    {m_held.aop, m_held.d, m_held.a, m_held.b, m_held.imm});
            end
            chk("rnd_stall_cnt", stall_cnt, m_cnt);
            chk("rnd_halted", halted, m_halted);
            if (in_valid && hz && !m_halted && m_cnt < 65535) m_cnt++;
            if (wb_valid) pend[wb_addr] = 1'b0;
            if (flush && m_ov && m_held.wd) pend[m_held.d] = 1'b0;
            if (acc && d.wd) pend[d.d] = 1'b1;
            if (m_halted && resume) m_halted = 1'b0;
            else if (acc && d.hlt) m_halted = 1'b1;
            if (flush) m_ov = 1'b0;
            else if (acc) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
            if (acc) m_held = d;
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Registered, handshaked successor to the combinational instruction decoder. It accepts one instruction per cycle over valid/ready, decodes it into register-file, ALU and memory controls, and holds the result in an output pipeline register. An internal scoreboard blocks instructions that depend on in-flight register writes. A HALT state machine stops fetch until resumed. It sits between the fetch stage and the register-read/execute stage.

Parameters:
INSTR_WIDTH, 32, instruction width in bits.
OPCODE_WIDTH, 4, major opcode field width; only 4 is legal, and any other value is an elaboration error.
REG_ADDR_WIDTH, 5, register address width; the scoreboard has 2**REG_ADDR_WIDTH bits.
ALU_OP_WIDTH, 3, ALU operation code width.
STALL_CNT_WIDTH, 16, width of the hazard-stall counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  instruction valid.
in_ready  out  1  stage can accept the instruction this cycle.
instr_in  in  INSTR_WIDTH  instruction word.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  downstream accepts the bundle.
read_src_a / read_src_b  out  1  each  source-read enables.
src_reg_addr_a / src_reg_addr_b  out  REG_ADDR_WIDTH  each  source register addresses.
write_dest  out  1  destination-write enable.
dest_reg_addr  out  REG_ADDR_WIDTH  destination register address.
alu_en  out  1  ALU used.
alu_op  out  ALU_OP_WIDTH  ALU operation.
use_imm  out  1  operand B comes from the immediate.
imm  out  IMM_W  immediate, where IMM_W = INSTR_WIDTH-OPCODE_WIDTH-2*REG_ADDR_WIDTH.
mem_rd / mem_wr / branch / halt  out  1  each  class flags.
wb_valid  in  1  writeback retire strobe.
wb_addr  in  REG_ADDR_WIDTH  register being retired.
flush  in  1  drop the held bundle.
resume  in  1  leave the HALTED state.
halted  out  1  FSM is in HALTED.
stall_cnt  out  STALL_CNT_WIDTH  saturating count of hazard-stall cycles.

Behaviour:
- Instruction fields, MSB first: opcode[W-1:W-4], dest, src_a, src_b. imm is the low IMM_W bits and overlaps src_b.
- Opcode decode:
  - 0: NOP. No reads, no write.
  - 1-7: ALU register-register. Reads a and b, writes dest, alu_en=1, alu_op=opcode[2:0].
  - 8-B: ALU immediate. Reads a, writes dest, alu_en=1, use_imm=1, alu_op={0,opcode[1:0]}.
  - C: LOAD. Reads a, writes dest, mem_rd=1, use_imm=1.
  - D: STORE. Reads a and b, mem_wr=1, use_imm=1.
  - E: BRANCH. Reads a and b, branch=1.
  - F: HALT. halt=1, all enables 0.
- Register r0 is constant zero. A decoded write to r0 has write_dest forced to 0. Reads of r0 never cause a hazard.
- Scoreboard:
  - Bit[r] is set when an instruction with write_dest=1 and dest r is loaded into the output register.
  - Bit[r] is cleared on wb_valid with wb_addr=r.
  - Set and clear of the same register in the same cycle: set wins.
- Hazard: a currently set scoreboard bit for any enabled non-r0 source, or for the destination (WAW). There is no bypass; a same-cycle clear does not release the stall.
- in_ready = state==RUN && !hazard && (!out_valid || out_ready) && !flush.
- Acceptance when in_valid && in_ready: the output register loads the decoded bundle and out_valid=1 on the next cycle (latency 1). Full throughput when there is no hazard.
- Held bundle: when out_valid && !out_ready, all outputs remain stable.
- stall_cnt increments each cycle that in_valid && hazard && state==RUN. It saturates at all-ones.
- FSM:
  - RUN -> HALTED when a HALT instruction is accepted.
  - HALTED -> RUN on resume. In HALTED, in_ready=0.
  - The HALT bundle itself still drains through out_valid/out_ready.
  - resume while in RUN is ignored.
- flush:
  - Clears out_valid next cycle.
  - Clears the scoreboard bit the dropped bundle set, if it had write_dest=1. A same-cycle wb_valid to a different register still applies.
  - Does not change FSM state.
  - Nothing is accepted in the flush cycle.
- Reset: state=RUN, out_valid=0, all decoded outputs 0, scoreboard all 0, stall_cnt=0, halted=0. Reset mid-transfer discards the held bundle.

Decomposition:
- Package decode_pkg holds:
  - opcode constants (OP_NOP … OP_HALT);
  - typedef decoded_t, a packed struct of all decoded fields;
  - field-position localparams;
  - the IMM_W function.
- One combinational sub-module, instr_field_decode (instruction -> decoded_t), reused by later stages. The FSM, scoreboard, handshake and counter stay in decode_stage.

Test Plan:
- Reset with in_valid=1, instr 0x11844000 -> in_ready=0 during reset. After release, a single cycle gives out_valid=1, dest 3, src 1/2, alu_op=1, write_dest=1.
- RAW: 0x11844000 then 0x120C0000 (r4 ← r3), out_ready=1, no wb -> second instruction stalls and stall_cnt increments each cycle. wb_valid wb_addr=3 -> accepted the following cycle.
- Write to r0 (0x10044000) followed by a read of r0 -> write_dest=0, no stall, back-to-back acceptance.
- Backpressure: out_ready=0 for 5 cycles with a valid output -> in_ready=0 and outputs stable. out_ready=1 -> next instruction accepted the same cycle.
- HALT 0xF0000000 -> halt=1 bundle emitted, halted=1, in_ready=0 for 10 cycles. resume pulse -> halted=0, fetch resumes.
- flush while holding 0x11844000 with out_ready=0 -> out_valid=0 next cycle and scoreboard bit 3 clear. A following read of r3 is accepted without stall.
